// File: rtl/lock_sequencer.sv
// Keypad lock controller: button edge detection, password compare, failed-attempt
// counting with lockout, tick-driven timeouts and password reprogramming.
module lock_sequencer #(
  parameter logic [6:0]  DEFAULT_PW    = 7'h2A,
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned INPUT_TICKS   = 16,
  parameter int unsigned OPEN_TICKS    = 32,
  parameter int unsigned LOCKOUT_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [6:0] code_in,
  input  logic       check_btn,
  input  logic       set_btn,
  output logic [2:0] state,
  output logic       unlocked,
  output logic       alarm,
  output logic       locked_out,
  output logic [2:0] fail_count,
  output logic       pw_updated
);

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_SET     = 3'b001;
  localparam logic [2:0] S_OPENED  = 3'b010;
  localparam logic [2:0] S_ALARM   = 3'b011;
  localparam logic [2:0] S_INPUT   = 3'b100;
  localparam logic [2:0] S_LOCKOUT = 3'b101;

  localparam logic [7:0] INPUT_LOAD   = 8'(INPUT_TICKS);
  localparam logic [7:0] OPEN_LOAD    = 8'(OPEN_TICKS);
  localparam logic [7:0] LOCKOUT_LOAD = 8'(LOCKOUT_TICKS);
  localparam logic [2:0] FAIL_LIMIT   = 3'(MAX_FAILS);

  logic [2:0] state_q, state_d;
  logic [6:0] pw_q, pw_d;
  logic [2:0] fail_q, fail_d;
  logic [7:0] timer_q, timer_d;
  logic       pw_upd_q, pw_upd_d;
  logic       check_lvl_q, set_lvl_q;

  logic       check_press, set_press, timed, timeout;
  logic [2:0] fail_inc;

  // A simultaneous check press masks the set press.
  assign check_press = check_btn & ~check_lvl_q;
  assign set_press   = set_btn & ~set_lvl_q & ~check_press;
  assign timed       = (state_q == S_INPUT) || (state_q == S_SET) ||
                       (state_q == S_OPENED) || (state_q == S_LOCKOUT);
  assign timeout     = timed & tick & (timer_q == 8'd1);
  assign fail_inc    = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    pw_d     = pw_q;
    fail_d   = fail_q;
    pw_upd_d = 1'b0;
    timer_d  = (timed && tick && (timer_q > 8'd1)) ? timer_q - 8'd1 : timer_q;

    case (state_q)
      S_IDLE: begin
        if (check_press) begin
          state_d = S_INPUT;
          timer_d = INPUT_LOAD;
        end
      end
      S_INPUT: begin
        if (check_press) begin
          if (code_in == pw_q) begin
            state_d = S_OPENED;
            fail_d  = 3'd0;
            timer_d = OPEN_LOAD;
          end else begin
            fail_d = fail_inc;
            if (fail_inc == FAIL_LIMIT) begin
              state_d = S_LOCKOUT;
              timer_d = LOCKOUT_LOAD;
            end else begin
              state_d = S_ALARM;
            end
          end
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_OPENED: begin
        if (check_press) begin
          state_d = S_IDLE;
        end else if (set_press) begin
          state_d = S_SET;
          timer_d = INPUT_LOAD;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_SET: begin
        if (check_press) begin
          pw_d     = code_in;
          pw_upd_d = 1'b1;
          state_d  = S_IDLE;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_ALARM: begin
        if (check_press) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (timeout) begin
          state_d = S_IDLE;
          fail_d  = 3'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Button level registers load during reset so a held button is not a press.
  always_ff @(posedge clk) begin
    check_lvl_q <= check_btn;
    set_lvl_q   <= set_btn;
    if (rst) begin
      state_q  <= S_IDLE;
      pw_q     <= DEFAULT_PW;
      fail_q   <= 3'd0;
      timer_q  <= 8'd0;
      pw_upd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pw_q     <= pw_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      pw_upd_q <= pw_upd_d;
    end
  end

  assign state      = state_q;
  assign unlocked   = (state_q == S_OPENED);
  assign alarm      = (state_q == S_ALARM) || (state_q == S_LOCKOUT);
  assign locked_out = (state_q == S_LOCKOUT);
  assign fail_count = fail_q;
  assign pw_updated = pw_upd_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Testbench for lock_sequencer: directed scenarios plus a randomized run scored
// against an elapsed-tick behavioural model of the lock.
module tb_lock_sequencer;

  localparam logic [2:0] C_IDLE = 3'd0, C_SET = 3'd1, C_OPEN = 3'd2;
  localparam logic [2:0] C_ALARM = 3'd3, C_INPUT = 3'd4, C_LOCK = 3'd5;
  localparam int P_MAX = 3, P_IN = 16, P_OPEN = 32, P_LOCK = 64;

  logic       clk = 1'b0;
  logic       rst, tick, check_btn, set_btn;
  logic [6:0] code_in;
  logic [2:0] state, fail_count;
  logic       unlocked, alarm, locked_out, pw_updated;

  int checks = 0;
  int errors = 0;

  lock_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick), .code_in(code_in),
    .check_btn(check_btn), .set_btn(set_btn), .state(state),
    .unlocked(unlocked), .alarm(alarm), .locked_out(locked_out),
    .fail_count(fail_count), .pw_updated(pw_updated)
  );

  always #5 clk = ~clk;

  // Model: mode, password, fail count, ticks elapsed since entering the mode.
  logic [2:0] m_state;
  logic [6:0] m_pw;
  int         m_fails, m_elapsed, m_limit;
  bit         m_chk_prev, m_set_prev, m_pw_pulse, m_moved;

  task automatic enter(input logic [2:0] st, input int limit);
    m_state = st; m_limit = limit; m_elapsed = 0; m_moved = 1;
  endtask

  task automatic model_reset(input bit c, input bit s);
    m_state = C_IDLE; m_pw = 7'h2A; m_fails = 0; m_elapsed = 0; m_limit = 0;
    m_chk_prev = c; m_set_prev = s; m_pw_pulse = 0;
  endtask

  task automatic model_step(input bit t, input bit c, input bit s, input logic [6:0] code);
    bit cp, sp, timed, to;
    cp = c && !m_chk_prev;
    sp = s && !m_set_prev && !cp;
    m_chk_prev = c; m_set_prev = s; m_pw_pulse = 0; m_moved = 0;
    timed = (m_state == C_INPUT) || (m_state == C_SET) || (m_state == C_OPEN) || (m_state == C_LOCK);
    to = t && timed && (m_elapsed + 1 >= m_limit);
    case (m_state)
      C_IDLE:  if (cp) enter(C_INPUT, P_IN);
      C_INPUT: begin
        if (cp) begin
          if (code == m_pw) begin
            m_fails = 0; enter(C_OPEN, P_OPEN);
          end else begin
            m_fails = (m_fails < 7) ? m_fails + 1 : 7;
            if (m_fails == P_MAX) enter(C_LOCK, P_LOCK);
            else enter(C_ALARM, 0);
          end
        end else if (to) enter(C_IDLE, 0);
      end
      C_OPEN: begin
        if (cp) enter(C_IDLE, 0);
        else if (sp) enter(C_SET, P_IN);
        else if (to) enter(C_IDLE, 0);
      end
      C_SET: begin
        if (cp) begin m_pw = code; m_pw_pulse = 1; enter(C_IDLE, 0); end
        else if (to) enter(C_IDLE, 0);
      end
      C_ALARM: if (cp) enter(C_IDLE, 0);
      C_LOCK:  if (to) begin m_fails = 0; enter(C_IDLE, 0); end
      default: enter(C_IDLE, 0);
    endcase
    if (!m_moved && t && timed) m_elapsed++;
  endtask

  task automatic step(input bit r, input bit t, input bit c, input bit s, input logic [6:0] code);
    rst = r; tick = t; check_btn = c; set_btn = s; code_in = code;
    if (r) model_reset(c, s);
    else model_step(t, c, s, code);
    @(posedge clk);
    #1;
  endtask

  task automatic press_check(input logic [6:0] code);
    step(0, 0, 1, 0, code);
    step(0, 0, 0, 0, code);
  endtask

  task automatic press_set(input logic [6:0] code);
    step(0, 0, 0, 1, code);
    step(0, 0, 0, 0, code);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 0, 7'h00);
      step(0, 0, 0, 0, 7'h00);
    end
  endtask

  task automatic test_reset;
    step(1, 0, 1, 0, 7'h2A);
    step(1, 0, 1, 0, 7'h2A);
    checks++; if (state !== 3'b000) begin errors++; $display("FAIL reset_state got=%b exp=000", state); end
    checks++; if (fail_count !== 3'd0) begin errors++; $display("FAIL reset_fail got=%0d exp=0", fail_count); end
    checks++; if ({unlocked, alarm, locked_out, pw_updated} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {unlocked, alarm, locked_out, pw_updated});
    end
    step(0, 0, 1, 0, 7'h2A);
    checks++; if (state !== 3'b000) begin errors++; $display("FAIL held_through_reset got=%b exp=000", state); end
    step(0, 0, 0, 0, 7'h2A);
  endtask

  task automatic test_unlock_relock;
    press_check(7'h2A);
    checks++; if (state !== 3'b100) begin errors++; $display("FAIL unlock_enter got=%b exp=100", state); end
    press_check(7'h2A);
    checks++; if (state !== 3'b010 || unlocked !== 1'b1 || fail_count !== 3'd0) begin
      errors++; $display("FAIL unlock_open got=%b/%b/%0d exp=010/1/0", state, unlocked, fail_count);
    end
    ticks(31);
    checks++; if (state !== 3'b010) begin errors++; $display("FAIL open_31ticks got=%b exp=010", state); end
    ticks(1);
    checks++; if (state !== 3'b000 || unlocked !== 1'b0) begin
      errors++; $display("FAIL open_timeout got=%b/%b exp=000/0", state, unlocked);
    end
  endtask

  task automatic test_lockout;
    for (int i = 1; i <= 3; i++) begin
      press_check(7'h11);
      press_check(7'h11);
      checks++; if (state !== ((i < 3) ? 3'b011 : 3'b101) || fail_count !== 3'(i)) begin
        errors++; $display("FAIL wrong_entry_%0d got=%b/%0d exp=%b/%0d", i, state, fail_count, (i < 3) ? 3'b011 : 3'b101, i);
      end
      if (i < 3) press_check(7'h11);
    end
    checks++; if ({alarm, locked_out} !== 2'b11) begin errors++; $display("FAIL lockout_flags got=%b exp=11", {alarm, locked_out}); end
    press_check(7'h2A);
    press_set(7'h2A);
    checks++; if (state !== 3'b101) begin errors++; $display("FAIL lockout_ignore got=%b exp=101", state); end
    ticks(63);
    checks++; if (state !== 3'b101) begin errors++; $display("FAIL lockout_63ticks got=%b exp=101", state); end
    ticks(1);
    checks++; if (state !== 3'b000 || fail_count !== 3'd0 || locked_out !== 1'b0) begin
      errors++; $display("FAIL lockout_exit got=%b/%0d/%b exp=000/0/0", state, fail_count, locked_out);
    end
  endtask

  task automatic test_set_password;
    press_check(7'h2A);
    press_check(7'h2A);
    press_set(7'h05);
    checks++; if (state !== 3'b001) begin errors++; $display("FAIL set_enter got=%b exp=001", state); end
    step(0, 0, 1, 0, 7'h05);
    checks++; if (pw_updated !== 1'b1 || state !== 3'b000) begin
      errors++; $display("FAIL set_commit got=%b/%b exp=1/000", pw_updated, state);
    end
    step(0, 0, 0, 0, 7'h05);
    checks++; if (pw_updated !== 1'b0) begin errors++; $display("FAIL set_pulse_width got=%b exp=0", pw_updated); end
    press_check(7'h2A);
    press_check(7'h2A);
    checks++; if (state !== 3'b011 || fail_count !== 3'd1) begin
      errors++; $display("FAIL old_pw_rejected got=%b/%0d exp=011/1", state, fail_count);
    end
    press_check(7'h00);
    checks++; if (fail_count !== 3'd1) begin errors++; $display("FAIL ack_keeps_fail got=%0d exp=1", fail_count); end
    press_check(7'h05);
    press_check(7'h05);
    checks++; if (state !== 3'b010 || fail_count !== 3'd0) begin
      errors++; $display("FAIL new_pw_accepted got=%b/%0d exp=010/0", state, fail_count);
    end
  endtask

  task automatic test_input_timeout;
    press_check(7'h05);
    press_check(7'h05);
    ticks(15);
    checks++; if (state !== 3'b100) begin errors++; $display("FAIL input_15ticks got=%b exp=100", state); end
    step(0, 1, 1, 0, 7'h05);
    checks++; if (state !== 3'b010) begin errors++; $display("FAIL press_beats_timeout got=%b exp=010", state); end
    step(0, 0, 0, 0, 7'h05);
    press_check(7'h05);
    press_check(7'h05);
    press_check(7'h11);
    checks++; if (state !== 3'b011) begin errors++; $display("FAIL wrong_before_timeout got=%b exp=011", state); end
    press_check(7'h11);
    press_check(7'h11);
    ticks(16);
    checks++; if (state !== 3'b000 || fail_count !== 3'd1) begin
      errors++; $display("FAIL input_timeout got=%b/%0d exp=000/1", state, fail_count);
    end
  endtask

  task automatic test_back_to_back;
    press_check(7'h05);
    press_check(7'h05);
    step(0, 0, 1, 1, 7'h05);
    checks++; if (state !== 3'b000) begin errors++; $display("FAIL check_beats_set got=%b exp=000", state); end
    step(0, 0, 0, 0, 7'h05);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0, 7'h11);
      checks++; if (state !== 3'b100) begin errors++; $display("FAIL held_check_cycle%0d got=%b exp=100", i, state); end
    end
    step(0, 0, 0, 0, 7'h11);
  endtask

  task automatic test_reset_midop;
    step(1, 0, 0, 0, 7'h00);
    step(0, 0, 0, 0, 7'h00);
    press_check(7'h05);
    press_check(7'h05);
    checks++; if (state !== 3'b011) begin errors++; $display("FAIL pw_reverted got=%b exp=011", state); end
    press_check(7'h05);
    press_check(7'h2A);
    press_check(7'h2A);
    press_set(7'h2A);
    ticks(5);
    step(1, 0, 0, 0, 7'h00);
    checks++; if (state !== 3'b000 || fail_count !== 3'd0) begin
      errors++; $display("FAIL reset_in_set got=%b/%0d exp=000/0", state, fail_count);
    end
    step(0, 0, 0, 0, 7'h00);
    for (int i = 0; i < 3; i++) begin
      press_check(7'h33);
      press_check(7'h33);
      if (i < 2) press_check(7'h33);
    end
    ticks(10);
    step(1, 0, 0, 0, 7'h00);
    checks++; if (state !== 3'b000 || fail_count !== 3'd0 || locked_out !== 1'b0) begin
      errors++; $display("FAIL reset_in_lockout got=%b/%0d/%b exp=000/0/0", state, fail_count, locked_out);
    end
    step(0, 0, 0, 0, 7'h00);
  endtask

  task automatic test_random;
    bit c, s, t, r;
    logic [6:0] code;
    c = 0; s = 0;
    step(1, 0, 0, 0, 7'h00);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) c = !c;
      if ($urandom_range(0, 3) == 0) s = !s;
      t = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 499) == 0);
      case ($urandom_range(0, 3))
        0, 1: code = m_pw;
        2: code = 7'h2A;
        default: code = 7'($urandom);
      endcase
      step(r, t, c, s, code);
      checks++; if (state !== m_state) begin errors++; $display("FAIL rand_state_%0d got=%b exp=%b", i, state, m_state); end
      checks++; if (fail_count !== 3'(m_fails)) begin errors++; $display("FAIL rand_fail_%0d got=%0d exp=%0d", i, fail_count, m_fails); end
      checks++; if ({unlocked, alarm, locked_out} !== {m_state == C_OPEN, m_state == C_ALARM || m_state == C_LOCK, m_state == C_LOCK}) begin
        errors++; $display("FAIL rand_flags_%0d got=%b state_exp=%b", i, {unlocked, alarm, locked_out}, m_state);
      end
      checks++; if (pw_updated !== m_pw_pulse) begin errors++; $display("FAIL rand_pwupd_%0d got=%b exp=%b", i, pw_updated, m_pw_pulse); end
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; check_btn = 1'b0; set_btn = 1'b0; code_in = 7'h00;
    model_reset(0, 0);
    test_reset;
    test_unlock_relock;
    test_lockout;
    test_set_password;
    test_input_timeout;
    test_back_to_back;
    test_reset_midop;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
